// File: rtl/game_screen_pkg.sv
// Shared colour constants, palette lookup and display mode encodings for the
// animated OLED test-screen generator.
package game_screen_pkg;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] BROWN   = 16'h8204;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_CYCLE  = 2'd2,
        MODE_FLASH  = 2'd3
    } mode_t;

    function automatic logic [15:0] palette_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    palette_colour = RED;
            3'd1:    palette_colour = GREEN;
            3'd2:    palette_colour = BLUE;
            3'd3:    palette_colour = YELLOW;
            3'd4:    palette_colour = MAGENTA;
            3'd5:    palette_colour = CYAN;
            3'd6:    palette_colour = WHITE;
            default: palette_colour = BROWN;
        endcase
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Bouncing-sprite position tracker: moves one pixel diagonally per step and
// reflects off the screen edges, turning around within the same step.
module sprite_motion #(
    parameter int SCREEN_W = 96,
    parameter int SCREEN_H = 64,
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] sx,
    output logic [7:0] sy
);

    localparam logic [7:0] XMAX = 8'(SCREEN_W - SPRITE_W);
    localparam logic [7:0] YMAX = 8'(SCREEN_H - SPRITE_H);

    // dx/dy: 1 = moving towards larger coordinates
    logic dx;
    logic dy;

    always_ff @(posedge clk) begin
        if (reset) begin
            sx <= 8'd0;
            sy <= 8'd0;
            dx <= 1'b1;
            dy <= 1'b1;
        end else if (step) begin
            if (dx) begin
                if (sx == XMAX) begin
                    dx <= 1'b0;
                    sx <= sx - 8'd1;
                end else begin
                    sx <= sx + 8'd1;
                end
            end else begin
                if (sx == 8'd0) begin
                    dx <= 1'b1;
                    sx <= sx + 8'd1;
                end else begin
                    sx <= sx - 8'd1;
                end
            end

            if (dy) begin
                if (sy == YMAX) begin
                    dy <= 1'b0;
                    sy <= sy - 8'd1;
                end else begin
                    sy <= sy + 8'd1;
                end
            end else begin
                if (sy == 8'd0) begin
                    dy <= 1'b1;
                    sy <= sy + 8'd1;
                end else begin
                    sy <= sy - 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/game_screen_anim.sv
// Animated OLED pixel source: static fill, bouncing sprite, palette cycling or
// flashing, paced by a frame divider and sampled one pixel per clock.
module game_screen_anim
    import game_screen_pkg::*;
#(
    parameter int          SCREEN_W  = 96,
    parameter int          SCREEN_H  = 64,
    parameter int          SPRITE_W  = 8,
    parameter int          SPRITE_H  = 8,
    parameter logic [15:0] BG_COLOUR = 16'h5FFF,
    parameter int          FRAME_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic [1:0]  mode,
    input  logic        pause,
    output logic [15:0] oled_data
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CNT_W-1:0] step_cnt;
    logic [2:0]       pal_idx;
    logic             flash;
    logic             advance;
    logic             step;
    logic [7:0]       sx;
    logic [7:0]       sy;
    logic [7:0]       x_w;
    logic [7:0]       y_w;
    logic             in_sprite;
    logic [15:0]      pix_p0;
    mode_t            mode_sel;

    assign mode_sel = mode_t'(mode);
    assign advance  = frame_begin & ~pause;
    assign step     = advance && (step_cnt == CNT_W'(FRAME_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
            pal_idx  <= 3'd0;
            flash    <= 1'b0;
        end else if (advance) begin
            step_cnt <= step ? '0 : step_cnt + CNT_W'(1);
            if (step && mode_sel == MODE_CYCLE) pal_idx <= pal_idx + 3'd1;
            if (step && mode_sel == MODE_FLASH) flash <= ~flash;
        end
    end

    sprite_motion #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_motion (
        .clk   (clk),
        .reset (reset),
        .step  (step && mode_sel == MODE_BOUNCE),
        .sx    (sx),
        .sy    (sy)
    );

    // 8-bit compares keep sx+SPRITE_W from wrapping at the right edge
    assign x_w       = {1'b0, x};
    assign y_w       = {2'b00, y};
    assign in_sprite = (x_w >= sx) && (x_w < sx + 8'(SPRITE_W)) &&
                       (y_w >= sy) && (y_w < sy + 8'(SPRITE_H));

    always_comb begin
        pix_p0 = BLACK;
        if (x_w < 8'(SCREEN_W) && y_w < 8'(SCREEN_H)) begin
            case (mode_sel)
                MODE_STATIC: pix_p0 = BG_COLOUR;
                MODE_BOUNCE: pix_p0 = in_sprite ? palette_colour(pal_idx) : BG_COLOUR;
                MODE_CYCLE:  pix_p0 = palette_colour(pal_idx);
                default:     pix_p0 = flash ? BLACK : BG_COLOUR;
            endcase
        end
    end

    // stage p0 -> output register
    always_ff @(posedge clk) begin
        if (reset) oled_data <= 16'h0000;
        else       oled_data <= pix_p0;
    end

endmodule
